// File: rtl/btn_debounce_pkg.sv
// Shared types and sizing helpers for the multi-channel button conditioner.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, stable-time debouncer and hold FSM
// producing registered one-cycle press/release/long/repeat pulses.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int ACTIVE_LOW    = 0,
  parameter int STABLE_CYCLES = 65536,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam logic INV    = (ACTIVE_LOW != 0);
  localparam logic REP_EN = (REPEAT_CYCLES > 0);
  localparam int   SW     = cnt_width(STABLE_CYCLES);
  localparam int   HW     = cnt_width(max_int(LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REP_EN ? REPEAT_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  hold_state_t   state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  logic s, diff, accept, rise, fall;

  // Synchroniser resets to the released pin level so reset exit is silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{INV}};
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign s      = sync_q[1] ^ INV;
  assign diff   = (s != level_q);
  assign accept = diff && (stab_cnt_q == STAB_LAST);
  assign rise   = accept && s;
  assign fall   = accept && !s;

  always_comb begin
    level_d    = level_q;
    stab_cnt_d = '0;
    if (accept) begin
      level_d = s;
    end else if (diff) begin
      stab_cnt_d = stab_cnt_q + STAB_ONE;
    end
  end

  // Release is tested first so it wins over a coincident long/repeat count.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d    = IDLE;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d    = HELD;
          long_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      HELD: begin
        if (fall) begin
          state_d    = IDLE;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end else if (REP_EN) begin
          if (hold_cnt_q == REP_LAST) begin
            repeat_d   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q    <= 1'b0;
      stab_cnt_q <= '0;
      hold_cnt_q <= '0;
      state_q    <= IDLE;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      level_q    <= level_d;
      stab_cnt_q <= stab_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N independent button channels; pure structural wrapper around btn_debounce_ch.
module btn_debounce_multi
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int ACTIVE_LOW    = 0,
  parameter int STABLE_CYCLES = 65536,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i]),
      .long_o   (long_pulse[i]),
      .repeat_o (repeat_pulse[i])
    );
  end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised N-channel push-button conditioner. Each channel has its own input synchroniser, stable-time debouncer and hold state machine. The block generalises our single-button debounce to configurable polarity, stable time, long-press detection and auto-repeat. It sits between the board button pins and the UART/plotter control logic, which consume its one-cycle event pulses.

## Interface
- `N_BTN`, default 4: number of independent channels.
- `ACTIVE_LOW`, default 0: 1 means the pin reads 0 when pressed. Inversion is applied after the synchroniser.
- `STABLE_CYCLES`, default 65536: consecutive cycles a new input level must persist before it is accepted. Must be ≥1.
- `LONG_CYCLES`, default 50_000_000: cycles of accepted press before the long-press event. Must be ≥1.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period after a long press. 0 disables repeat.
- `clk` input 1: single clock domain.
- `rst` input 1: asynchronous, active-high reset.
- `btn_in` input N_BTN: raw asynchronous button pins.
- `btn_level` output N_BTN: debounced level, 1 = pressed.
- `press_pulse` output N_BTN: one-cycle pulse on accepted press.
- `release_pulse` output N_BTN: one-cycle pulse on accepted release.
- `long_pulse` output N_BTN: one-cycle pulse when a press has lasted LONG_CYCLES.
- `repeat_pulse` output N_BTN: one-cycle pulse every REPEAT_CYCLES while held past the long press.

## Operation
- **Synchroniser.** Each channel uses a 2-FF synchroniser. Its reset value is the released pin level: 1 if ACTIVE_LOW, else 0. Consequently no spurious press occurs when reset releases.
- **Debouncer.**
  - Let `s` be the synchronised, polarity-corrected input. `stab_cnt` counts consecutive cycles with `s != btn_level`.
  - `stab_cnt` clears to 0 on any cycle where `s == btn_level`.
  - When `s != btn_level` and `stab_cnt == STABLE_CYCLES-1`, `btn_level <= s` and `stab_cnt <= 0`.
  - Glitches shorter than STABLE_CYCLES never change `btn_level`.
- **Hold FSM.** One instance per channel, with states IDLE, PRESSED and HELD.
  - IDLE → PRESSED on the `btn_level` 0→1 edge. `press_pulse` asserts and `hold_cnt` clears.
  - PRESSED: `hold_cnt` increments each cycle. At `hold_cnt == LONG_CYCLES-1` the FSM moves to HELD, `long_pulse` asserts and `hold_cnt` clears.
  - HELD with REPEAT_CYCLES > 0: `hold_cnt` increments. At `REPEAT_CYCLES-1`, `repeat_pulse` asserts and `hold_cnt` wraps to 0.
  - HELD with REPEAT_CYCLES = 0: the FSM stays in HELD and emits no pulses.
  - PRESSED or HELD → IDLE on the `btn_level` 1→0 edge. `release_pulse` asserts and `hold_cnt` clears.
  - Release has priority: if a release coincides with a long or repeat terminal count, only `release_pulse` fires.
- **Counter widths.**
  - `stab_cnt` is `$clog2(STABLE_CYCLES+1)` bits.
  - `hold_cnt` is `$clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1)` bits.
  - Neither counter can overflow, because each is cleared or wrapped at its terminal count.
- **Channel independence.** Channels share no state. Simultaneous events on several channels produce simultaneous pulses.

## Timing
- **Reset values.**
  - All outputs are 0 during and after reset.
  - FSM = IDLE, counters = 0.
  - Synchronisers hold the released level.
- **Press latency.** A pin change first sampled at edge k gives `s` changed after edge k+1. `btn_level` and `press_pulse` then update at edge k+1+STABLE_CYCLES.
- **Release latency.** Same as press latency.
- **Long-press latency.** `long_pulse` asserts exactly LONG_CYCLES cycles after `press_pulse`.
- **Repeat timing.**
  - The first `repeat_pulse` asserts REPEAT_CYCLES cycles after `long_pulse`.
  - Subsequent pulses are spaced by exactly REPEAT_CYCLES.
- **Pulse outputs.** Every pulse output is registered and high for exactly one cycle. No channel ever has two pulse outputs high in the same cycle.
- **Reset mid-operation.** Asserting `rst` at any time returns the channel to IDLE immediately (asynchronously) with no `release_pulse` emitted. If the pin is still pressed after reset, a fresh `press_pulse` follows after the full latency.

## Structure
- **Package `btn_debounce_pkg`.**
  - Typedef `hold_state_t` enum {IDLE, PRESSED, HELD}.
  - Function `cnt_width(int)` wrapping `$clog2(n+1)`.
- **Sub-module `btn_debounce_ch`.** Contains one channel: synchroniser, debouncer and hold FSM, with scalar ports and the same parameters.
- **Top level.** The top instantiates `btn_debounce_ch` N_BTN times in a generate loop and contains no other logic.

## Test plan
All scenarios use N_BTN=4, STABLE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=16 unless noted.
- **Clean press, then hold.** `btn_in[0]` 0→1 held 100 cycles, then 0 for 20 cycles. Required response, in order:
  - `press_pulse[0]` after 10 cycles.
  - `long_pulse[0]` 32 cycles after the press.
  - `repeat_pulse[0]` at +16 and +32 after the long pulse.
  - `release_pulse[0]` 10 cycles after the falling edge.
  - `btn_level[0]` tracks throughout.
- **Bounce rejection.** `btn_in[1]` toggles with high times of 3, 5 and 7 cycles, separated by 1-cycle lows, then stays high. Required: no pulse from the toggles, and a single `press_pulse[1]` 10 cycles after the final rising edge.
- **Active-low with repeat disabled.** ACTIVE_LOW=1, REPEAT_CYCLES=0, all pins 1 through reset. Required:
  - No pulses at reset release.
  - Pulling `btn_in[2]` low for 200 cycles gives one press pulse and one long pulse, and zero repeat pulses.
- **Release racing long press.** Release `btn_in[3]` timed so the `btn_level` fall coincides with `hold_cnt == 31`. Required: only `release_pulse[3]` fires, with no `long_pulse[3]`.
- **Reset mid-hold, multi-channel.**
  - Press channels 0 and 2 in the same cycle. Required: simultaneous `press_pulse` on both.
  - Assert `rst` while in HELD, with pins still high. Required: outputs drop to 0 with no release pulse, and fresh press pulses 10 cycles after reset deasserts.
